// File: rtl/sin_24b_arbiter_if.sv
// Bundle of request, core and response signals for the sin_24b arbiter.
// slave is the arbiter's view; master is the producer/consumer/core side.
interface sin_24b_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*24-1:0] req_data;
  logic [23:0]        core_in;
  logic [24:0]        core_out;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [24:0]        rsp_data;
  logic [IDW-1:0]     rsp_id;
  logic               busy;
  logic [31:0]        done_count;

  modport slave (
    input  req_valid, req_data, core_out, rsp_ready,
    output req_ready, core_in, rsp_valid, rsp_data, rsp_id, busy, done_count
  );

  modport master (
    output req_valid, req_data, core_out, rsp_ready,
    input  req_ready, core_in, rsp_valid, rsp_data, rsp_id, busy, done_count
  );
endinterface

// File: rtl/sin_24b_arbiter.sv
// Round-robin share of one combinational sin_24b core; result valid SETTLE+1 cycles after grant.
// Grants only from IDLE; a stalled response (rsp_ready low) holds the arbiter in RESP.
module sin_24b_arbiter #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int SETTLE = 1
) (
  input logic            clk,
  input logic            rst,
  sin_24b_arbiter_if.slave bus
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [PW:0]   NREQ_W   = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [23:0]     core_in_q;
  logic            rsp_valid_q;
  logic [24:0]     rsp_data_q;
  logic [IDW-1:0]  rsp_id_q;
  logic            busy_q;
  logic [31:0]     done_count_q;

  logic            gnt_found;
  logic [PW-1:0]   gnt_idx;
  logic [PW:0]     scan_w;
  logic [PW-1:0]   ptr_d;
  logic [23:0]     core_in_d;
  logic [IDW-1:0]  rsp_id_d;
  logic [NREQ-1:0] req_ready_d;

  // Scan from ptr upward with wraparound; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_w    = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_w = {1'b0, ptr_q} + (PW+1)'(i);
      if (scan_w >= NREQ_W) begin
        scan_w = scan_w - NREQ_W;
      end
      if (!gnt_found && bus.req_valid[scan_w[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_w[PW-1:0];
      end
    end
  end

  always_comb begin
    ptr_d       = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PW'(1);
    core_in_d   = bus.req_data[gnt_idx*24 +: 24];
    rsp_id_d    = IDW'(gnt_idx);
    req_ready_d = '0;
    if (state_q == ST_IDLE && !rst && gnt_found) begin
      req_ready_d[gnt_idx] = 1'b1;
    end
  end

  // core_in is deliberately left untouched outside a grant to keep the core quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      core_in_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      busy_q       <= 1'b0;
      done_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_found) begin
            core_in_q <= core_in_d;
            rsp_id_q  <= rsp_id_d;
            ptr_q     <= ptr_d;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            rsp_data_q  <= bus.core_out;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q  <= 1'b0;
            done_count_q <= done_count_q + 32'd1;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_d;
  assign bus.core_in    = core_in_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.busy       = busy_q;
  assign bus.done_count = done_count_q;

endmodule

// File: tb/tb_sin_24b_arbiter.sv
// Random-stimulus bench: cycle-level transaction model feeds a scoreboard queue,
// a negedge monitor compares handshakes, timing and captured results.
module tb_sin_24b_arbiter;

  localparam int NREQ   = 5;
  localparam int IDW    = 4;
  localparam int SETTLE = 3;
  localparam int INF    = 32'h7fffffff;

  typedef struct {
    int          id;
    logic [23:0] d;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sin_24b_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  sin_24b_arbiter #(.NREQ(NREQ), .IDW(IDW), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at cycle-time %0t", name, act, exp, $time);
    end
  endtask

  function automatic int grant(input logic [NREQ-1:0] v, input int ptr);
    for (int i = 0; i < NREQ; i++) begin
      if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    end
    return -1;
  endfunction

  // Core stand-in: correct only once core_in has been steady for SETTLE-1 cycles.
  function automatic logic [24:0] good(input logic [23:0] x);
    return {^x, x ^ 24'h5A5A5A};
  endfunction

  logic [23:0] last_core;
  int          stable = 0;
  always @(negedge clk) begin
    if (bus.core_in !== last_core) begin
      stable    = 0;
      last_core = bus.core_in;
    end else begin
      stable++;
    end
    bus.core_out = (stable >= SETTLE - 1) ? good(bus.core_in) : ~good(bus.core_in);
  end

  // Reference model: which cycles are idle, when responses appear, what they hold.
  int   cyc = 0;
  int   m_ptr = 0;
  int   m_idle_at = INF;
  int   m_resp_at = INF;
  int   m_cnt = 0;
  bit   started = 0;
  bit   rst_edge = 0;
  exp_t q[$];
  int   gm;

  always @(posedge clk) begin
    if (rst) begin
      m_ptr     = 0;
      m_idle_at = cyc + 1;
      m_resp_at = INF;
      m_cnt     = 0;
      q.delete();
      started   = 1;
      rst_edge  = 1;
    end else begin
      rst_edge = 0;
      if (started) begin
        if (cyc >= m_idle_at) begin
          gm = grant(bus.req_valid, m_ptr);
          if (gm >= 0) begin
            q.push_back('{id: gm, d: bus.req_data[gm*24 +: 24], due: cyc + SETTLE + 1});
            m_ptr     = (gm + 1) % NREQ;
            m_idle_at = INF;
            m_resp_at = cyc + SETTLE + 1;
          end
        end else if (cyc >= m_resp_at && bus.rsp_ready) begin
          m_cnt     = m_cnt + 1;
          m_idle_at = cyc + 1;
          m_resp_at = INF;
        end
      end
    end
    cyc++;
  end

  // Monitor
  bit              prev_rv = 0;
  bit              have_cur = 0;
  exp_t            cur;
  logic [NREQ-1:0] exp_rdy;
  int              gc;
  bit              idle;

  always @(negedge clk) begin
    if (started) begin
      idle    = (cyc >= m_idle_at);
      exp_rdy = '0;
      if (idle && !rst) begin
        gc = grant(bus.req_valid, m_ptr);
        if (gc >= 0) exp_rdy[gc] = 1'b1;
      end
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      chk("busy", 64'(bus.busy), 64'(!idle));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(cyc >= m_resp_at));
      chk("done_count", 64'(bus.done_count), 64'(m_cnt));
      if (rst_edge) begin
        have_cur = 0;
        chk("reset_core_in", 64'(bus.core_in), 64'd0);
        chk("reset_rsp_data", 64'(bus.rsp_data), 64'd0);
        chk("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
      end
      if (bus.rsp_valid === 1'b1 && !prev_rv) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rsp: rsp_valid rose with nothing outstanding at %0t", $time);
          have_cur = 0;
        end else begin
          cur      = q.pop_front();
          have_cur = 1;
          chk("rsp_latency", 64'(cyc), 64'(cur.due));
        end
      end
      if (bus.rsp_valid === 1'b1 && have_cur) begin
        chk("rsp_data", 64'(bus.rsp_data), 64'(good(cur.d)));
        chk("rsp_id", 64'(bus.rsp_id), 64'(cur.id));
        chk("core_in_hold", 64'(bus.core_in), 64'(cur.d));
      end else if (q.size() > 0 && cyc < m_resp_at) begin
        chk("core_in", 64'(bus.core_in), 64'(q[0].d));
      end
      prev_rv = (bus.rsp_valid === 1'b1);
    end
  end

  // Stimulus: granted or idle requesters get a fresh operand with probability p_new.
  task automatic drive_cycle(input int p_new, input int p_rdy);
    logic [NREQ-1:0] gnt_seen;
    @(negedge clk);
    gnt_seen = bus.req_ready & bus.req_valid;
    @(posedge clk);
    #1;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_seen[k] || !bus.req_valid[k]) begin
        if ($urandom_range(99) < p_new) begin
          bus.req_valid[k]          = 1'b1;
          bus.req_data[k*24 +: 24]  = 24'($urandom);
        end else begin
          bus.req_valid[k] = 1'b0;
        end
      end
    end
    bus.rsp_ready = ($urandom_range(99) < p_rdy);
  endtask

  bit found;

  initial begin
    rst           = 1'b1;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < NREQ; k++) bus.req_data[k*24 +: 24] = 24'($urandom);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Everyone busy: strict rotation with a free-running consumer.
    repeat (60) drive_cycle(100, 100);
    // Stalled consumer.
    repeat (8) drive_cycle(100, 0);
    repeat (10) drive_cycle(100, 100);
    // Sparse random traffic with random backpressure.
    repeat (400) drive_cycle(30, 60);
    // Single requester at a time.
    repeat (40) drive_cycle(8, 70);

    found = 0;
    for (int i = 0; i < 50; i++) begin
      drive_cycle(100, 100);
      if (bus.busy && !bus.rsp_valid) begin
        found = 1;
        break;
      end
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL reach_wait: arbiter never observed in WAIT within 50 cycles");
    end
    rst           = 1'b1;
    bus.req_valid = '1;
    drive_cycle(100, 100);
    rst = 1'b0;
    repeat (40) drive_cycle(100, 100);
    repeat (100) drive_cycle(40, 50);
    repeat (30) drive_cycle(0, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sin_24b_arbiter.md
Name: sin_24b_arbiter

Overview:
- Shares one combinational sin_24b core (24-bit operand in, 25-bit result out) among NREQ requesters using round-robin arbitration.
- Registers the selected operand onto the core input and waits a programmable settle time, since approximate netlists can have long combinational paths.
- Captures the result and returns it with the requester ID over a valid/ready response channel.
- Sits between operand producers (dataset streamers, test harness) and the core under evaluation.

Parameters:
- NREQ, 4, number of requesters; 2..16, need not be a power of 2.
- IDW, 2, width of rsp_id; must be at least clog2(NREQ).
- SETTLE, 1, cycles core_in is held stable before core_out is sampled; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_data  input  NREQ*24  operands, flattened; requester k occupies bits [24k+23:24k].
- req_ready  output  NREQ  one-hot grant, combinational, asserted only in IDLE.
- core_in  output  24  registered operand driven to the sin_24b core.
- core_out  input  25  sin_24b result.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  25  captured core_out.
- rsp_id  output  IDW  index of the requester served.
- busy  output  1  high whenever state is not IDLE.
- done_count  output  32  completed responses; wraps.

Behaviour:
- Reset values: state=IDLE, ptr=0, cnt=0, core_in=0, rsp_valid=0, rsp_data=0, rsp_id=0, done_count=0, busy=0. Reset in any state aborts the operation; no response is produced.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - grant g = first k with req_valid[k]=1, searching ptr, ptr+1, ... mod NREQ. req_ready[g]=1; all other req_ready bits 0. req_ready=0 if no request.
  - When a grant is made, the handshake completes that cycle. Next edge: core_in<=req_data[g], rsp_id<=g, ptr<=(g+1) mod NREQ (NREQ-1 wraps to 0), cnt<=0, state<=WAIT.
- WAIT:
  - req_ready=0. cnt increments each cycle.
  - When cnt==SETTLE-1: rsp_data<=core_out, rsp_valid<=1, state<=RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held stable.
  - On rsp_ready=1: rsp_valid<=0, done_count<=done_count+1 (wraps 2^32-1 to 0), state<=IDLE.
  - A new grant cannot occur in the same cycle as rsp_ready.
- Latency: handshake in cycle T gives rsp_valid high from cycle T+SETTLE+1. Peak throughput is one result per SETTLE+2 cycles.
- core_in holds its last operand in RESP/IDLE until the next grant. It is never returned to 0, to avoid spurious switching activity in power runs.
- Requesters must hold req_valid and req_data until granted. Changes to a non-granted requester have no effect.
- Simultaneous requests are resolved only by ptr. A requester that is continuously valid is served at least once every NREQ transactions.
- Unused upper rsp_id bits (IDW > clog2(NREQ)) are 0.

Test Plan:
- Reset: hold rst for 2 cycles with all req_valid=1 -> req_ready=0 during reset; every output at its reset value; first grant after release goes to requester 0.
- Single request, SETTLE=1: req_valid=4'b0100, req_data[2]=24'h00ABCD at cycle T; bench core model returns {1'b1,core_in} -> core_in=24'h00ABCD from T+1, rsp_valid at T+2, rsp_data=25'h100ABCD, rsp_id=2, done_count=1 after rsp_ready.
- Round-robin: req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; ptr wraps 3 to 0.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable, busy=1, req_ready=0; rsp_ready=1 -> return to IDLE on the next edge.
- SETTLE=4: core model output changes mid-WAIT -> rsp_data equals the core_out value on the 4th WAIT cycle; rsp_valid at T+5.
- Reset mid-WAIT: rst asserted during WAIT -> no rsp_valid, done_count=0, state IDLE, ptr=0.
